add_pipe: RTL and testbench

- Parametrised, pipelined add/subtract unit; successor to the combinational adder.
- Splits the carry chain into NumStages equal slices, one registered slice per stage, so wide adds close timing at the core clock.
- Valid/ready on both sides; feeds the ALU and the address generation path.
- Supports add, subtract and carry/borrow chaining for multi-word arithmetic.

---
 rtl/add_pkg.sv | 16 +
 rtl/add_slice.sv | 25 ++
 rtl/add_pipe.sv | 166 ++++++++++++++++
 tb/tb_add_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit (add_pipe).
// Used by both flag builds (ADD_PIPE_FLAGS_EN defined or not).
package add_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } add_op_e;

    // A zero stage count yields the full width so the top-level range check can report it.
    function automatic int unsigned slice_width(input int unsigned bit_width,
                                                input int unsigned num_stages);
        return (num_stages == 0) ? bit_width : bit_width / num_stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational Width-bit adder slice used by each add_pipe stage.
// The zero output exists only when ADD_PIPE_FLAGS_EN is defined.
module add_slice #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             cin,
    output logic [Width-1:0] y,
    output logic             cout
`ifdef ADD_PIPE_FLAGS_EN
    ,
    output logic             zero
`endif
);

    always_comb begin
        {cout, y} = {1'b0, a} + {1'b0, b} + {{Width{1'b0}}, cin};
    end

`ifdef ADD_PIPE_FLAGS_EN
    assign zero = (y == '0);
`endif

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract: the carry chain is cut into NumStages registered slices.
// Define ADD_PIPE_FLAGS_EN to build the overflow/zero flag logic; otherwise both tie to 0.
module add_pipe
    import add_pkg::*;
#(
    parameter int unsigned BitWidth  = 32,
    parameter int unsigned NumStages = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BitWidth-1:0] a,
    input  logic [BitWidth-1:0] b,
    input  logic                cin,
    input  add_op_e             sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BitWidth-1:0] y,
    output logic                cout,
    output logic                overflow,
    output logic                zero
);

    localparam int unsigned W = slice_width(BitWidth, NumStages);

    if ((NumStages < 1) || (W * NumStages != BitWidth)) begin : g_bad_cfg
        $error("add_pipe: BitWidth must be a nonzero multiple of NumStages");
    end

    logic                adv;
    logic [BitWidth-1:0] b_eff;
    logic                c0;

    logic [NumStages-1:0] vld_q, vld_d;
    logic [BitWidth-1:0]  a_q [NumStages];
    logic [BitWidth-1:0]  a_d [NumStages];
    logic [BitWidth-1:0]  b_q [NumStages];
    logic [BitWidth-1:0]  b_d [NumStages];
    logic [BitWidth-1:0]  y_q [NumStages];
    logic [BitWidth-1:0]  y_d [NumStages];
    logic                 c_q [NumStages];
    logic                 c_d [NumStages];

`ifdef ADD_PIPE_FLAGS_EN
    logic z_q [NumStages];
    logic z_d [NumStages];
    logic ov_q, ov_d;
`endif

    assign b_eff = (sub == SUB) ? ~b : b;
    assign c0    = cin ^ (sub == SUB);

    // Single advance enable: the whole pipe moves or the whole pipe holds.
    assign adv       = !vld_q[NumStages-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NumStages-1];
    assign y         = y_q[NumStages-1];
    assign cout      = c_q[NumStages-1];

    for (genvar k = 0; k < NumStages; k++) begin : g_stage
        logic [BitWidth-1:0] src_a, src_b, src_y, nxt_y;
        logic                src_v, src_c, sl_co;
        logic [W-1:0]        sl_y;
`ifdef ADD_PIPE_FLAGS_EN
        logic                src_z, sl_z;
`endif

        if (k == 0) begin : g_head
            assign src_v = in_valid;
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = c0;
            assign src_y = '0;
        end else begin : g_body
            assign src_v = vld_q[k-1];
            assign src_a = a_q[k-1];
            assign src_b = b_q[k-1];
            assign src_c = c_q[k-1];
            assign src_y = y_q[k-1];
        end

        add_slice #(
            .Width(W)
        ) u_slice (
            .a   (src_a[k*W +: W]),
            .b   (src_b[k*W +: W]),
            .cin (src_c),
            .y   (sl_y),
            .cout(sl_co)
`ifdef ADD_PIPE_FLAGS_EN
            ,
            .zero(sl_z)
`endif
        );

        // Lower slices finished by earlier stages ride along; this stage fills its own slice.
        always_comb begin
            nxt_y = src_y;
            nxt_y[k*W +: W] = sl_y;
        end

        assign vld_d[k] = src_v;
        assign a_d[k]   = src_a;
        assign b_d[k]   = src_b;
        assign y_d[k]   = nxt_y;
        assign c_d[k]   = sl_co;

`ifdef ADD_PIPE_FLAGS_EN
        if (k == 0) begin : g_zhead
            assign src_z = 1'b1;
        end else begin : g_zbody
            assign src_z = z_q[k-1];
        end
        assign z_d[k] = src_z & sl_z;

        if (k == NumStages - 1) begin : g_ovf
            assign ov_d = (src_a[BitWidth-1] == src_b[BitWidth-1]) &&
                          (sl_y[W-1] != src_a[BitWidth-1]);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < NumStages; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                y_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            for (int k = 0; k < NumStages; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                y_q[k] <= y_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

`ifdef ADD_PIPE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q <= 1'b0;
            for (int k = 0; k < NumStages; k++) begin
                z_q[k] <= 1'b0;
            end
        end else if (adv) begin
            ov_q <= ov_d;
            for (int k = 0; k < NumStages; k++) begin
                z_q[k] <= z_d[k];
            end
        end
    end

    assign overflow = ov_q;
    assign zero     = z_q[NumStages-1];
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe in three configurations (8/2, 32/4, 8/1) with an arithmetic
// scoreboard; flag expectations follow whether ADD_PIPE_FLAGS_EN is defined.
module tb_add_pipe;
    import add_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [31:0] a_s, b_s;
    logic        cin_s;
    add_op_e     sub_s;
    logic        out_ready;
    int          sel;

    logic       iv0, ir0, vl0, co0, ovf0, z0;
    logic [7:0] y0;
    logic       iv1, ir1, vl1, co1, ovf1, z1;
    logic [31:0] y1;
    logic       iv2, ir2, vl2, co2, ovf2, z2;
    logic [7:0] y2;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    add_pipe #(.BitWidth(8), .NumStages(2)) u_p8x2 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a_s[7:0]), .b(b_s[7:0]),
        .cin(cin_s), .sub(sub_s), .out_valid(vl0), .out_ready(out_ready), .y(y0),
        .cout(co0), .overflow(ovf0), .zero(z0)
    );

    add_pipe u_p32x4 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_s), .b(b_s),
        .cin(cin_s), .sub(sub_s), .out_valid(vl1), .out_ready(out_ready), .y(y1),
        .cout(co1), .overflow(ovf1), .zero(z1)
    );

    add_pipe #(.BitWidth(8), .NumStages(1)) u_p8x1 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a_s[7:0]), .b(b_s[7:0]),
        .cin(cin_s), .sub(sub_s), .out_valid(vl2), .out_ready(out_ready), .y(y2),
        .cout(co2), .overflow(ovf2), .zero(z2)
    );

    logic        o_ir, o_vld, o_co, o_ovf, o_z;
    logic [31:0] o_y;
    always_comb begin
        o_ir = ir0; o_vld = vl0; o_y = {24'd0, y0}; o_co = co0; o_ovf = ovf0; o_z = z0;
        if (sel == 1) begin
            o_ir = ir1; o_vld = vl1; o_y = y1; o_co = co1; o_ovf = ovf1; o_z = z1;
        end else if (sel == 2) begin
            o_ir = ir2; o_vld = vl2; o_y = {24'd0, y2}; o_co = co2; o_ovf = ovf2; o_z = z2;
        end
    end

    typedef struct {
        logic [31:0] y;
        bit          co;
        bit          ovf;
        bit          z;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   bw, ns;
    int   checks, errors, cycle;
    bit   stalled, front_seen;

    // Reference: plain integer add/subtract with borrow and a signed range test.
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                   input bit tc, input bit ts);
        exp_t   e;
        longint ua, ub, sa, sb, r, lim, m, ci;
        m   = (longint'(1) << bw) - 1;
        lim = longint'(1) << (bw - 1);
        ci  = tc;
        ua  = longint'(ta) & m;
        ub  = longint'(tb) & m;
        if (!ts) begin
            r    = ua + ub + ci;
            e.co = ((r >> bw) & 1) != 0;
        end else begin
            r    = ua - ub - ci;
            e.co = (r >= 0);
        end
        e.y   = 32'(r & m);
        sa    = (ua >= lim) ? ua - 2 * lim : ua;
        sb    = (ub >= lim) ? ub - 2 * lim : ub;
        r     = ts ? sa - sb - ci : sa + sb + ci;
        e.ovf = (r >= lim) || (r < -lim);
        e.z   = (e.y == 0);
        e.acc = 0;
        return e;
    endfunction

    task automatic step(input bit v, input logic [31:0] ta, input logic [31:0] tb,
                        input bit tc, input bit ts, input bit ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; a_s = ta; b_s = tb; cin_s = tc; sub_s = ts ? SUB : ADD;
        out_ready = ordy;
        #1;
        cycle++;
        acc = v && (o_ir === 1'b1);
        checks++;
        if (o_ir !== (!o_vld || ordy)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", o_ir, (!o_vld || ordy));
        end
        if (o_vld === 1'b1) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out: out_valid=1 got y=%h want no beat", o_y);
            end else begin
                e = q[0];
                if (!front_seen && !stalled) begin
                    checks++;
                    if (cycle - e.acc != ns) begin
                        errors++;
                        $display("FAIL latency: got %0d want %0d", cycle - e.acc, ns);
                    end
                end
                front_seen = 1;
                checks++;
                if (o_y !== e.y || o_co !== e.co) begin
                    errors++;
                    $display("FAIL result: got y=%h cout=%b want y=%h cout=%b",
                             o_y, o_co, e.y, e.co);
                end
                checks++;
`ifdef ADD_PIPE_FLAGS_EN
                if (o_ovf !== e.ovf || o_z !== e.z) begin
                    errors++;
                    $display("FAIL flags: got ovf=%b zero=%b want ovf=%b zero=%b",
                             o_ovf, o_z, e.ovf, e.z);
                end
`else
                if (o_ovf !== 1'b0 || o_z !== 1'b0) begin
                    errors++;
                    $display("FAIL flags: got ovf=%b zero=%b want 0 0", o_ovf, o_z);
                end
`endif
                if (ordy) begin
                    void'(q.pop_front());
                    front_seen = 0;
                end else begin
                    stalled = 1;
                end
            end
        end
        if (acc) begin
            e = model(ta, tb, tc, ts);
            e.acc = cycle;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 0, 0, 0, 1, acc);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding want 0", q.size());
        end
        stalled = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_valid = 0; out_ready = 1;
        @(negedge clk);
        rst = 0;
        q.delete(); front_seen = 0; stalled = 0;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_y !== 32'd0 || o_co !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got vld=%b y=%h cout=%b want 0 0 0", o_vld, o_y, o_co);
        end
        checks++;
        if (o_ovf !== 1'b0 || o_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ovf=%b zero=%b want 0 0", o_ovf, o_z);
        end
        checks++;
        if (o_ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", o_ir);
        end
    endtask

    task automatic select(input int s, input int w, input int n);
        sel = s; bw = w; ns = n;
        do_reset();
    endtask

    task automatic random_stream(input int beats);
        bit acc;
        for (int i = 0; i < beats; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 2) != 0, acc);
        end
        drain();
    endtask

    task automatic test_reset();
        select(0, 8, 2);
    endtask

    task automatic test_slice_carry();
        logic [7:0] da [4] = '{8'h0F, 8'hFF, 8'h05, 8'h80};
        logic [7:0] db [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
        bit         ds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bit acc;
        select(0, 8, 2);
        for (int i = 0; i < 4; i++) begin
            step(1, {24'd0, da[i]}, {24'd0, db[i]}, 0, ds[i], 1, acc);
            step(0, 0, 0, 0, 0, 1, acc);
            step(0, 0, 0, 0, 0, 1, acc);
        end
        drain();
        random_stream(40);
    endtask

    task automatic test_back_to_back();
        bit acc, saw_low;
        int i;
        select(1, 32, 4);
        i = 0;
        saw_low = 0;
        for (int t = 0; t < 100 && i < 16; t++) begin
            step(1, i, i, 1, 0, !(t >= 6 && t <= 9), acc);
            if (o_ir === 1'b0) saw_low = 1;
            if (acc) i++;
        end
        checks++;
        if (i != 16) begin
            errors++;
            $display("FAIL b2b_accepted: got %0d want 16", i);
        end
        checks++;
        if (!saw_low) begin
            errors++;
            $display("FAIL b2b_hold: got in_ready never low want low during hold");
        end
        drain();
        random_stream(60);
    endtask

    task automatic test_reset_midflight();
        bit acc;
        select(1, 32, 4);
        for (int i = 0; i < 3; i++) step(1, $urandom, $urandom, 0, 0, 1, acc);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 1, acc);
            checks++;
            if (o_vld !== 1'b0) begin
                errors++;
                $display("FAIL flush: got out_valid=%b want 0", o_vld);
            end
        end
    endtask

    task automatic test_single_stage();
        bit acc;
        select(2, 8, 1);
        for (int i = 0; i < 32; i++) begin
            if (i < 16) step(1, i, 0, 1, 0, 1, acc);
            else step(1, 15, i - 16, 1, 0, 1, acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL sweep_accept: got in_ready=%b want 1", o_ir);
            end
        end
        drain();
        random_stream(40);
    endtask

    initial begin
        checks = 0; errors = 0; cycle = 0;
        stalled = 0; front_seen = 0;
        rst = 1; in_valid = 0; a_s = '0; b_s = '0; cin_s = 0; sub_s = ADD; out_ready = 1;
        sel = 0; bw = 8; ns = 2;
        repeat (2) @(negedge clk);
        test_reset();
        test_slice_carry();
        test_back_to_back();
        test_reset_midflight();
        test_single_stage();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
